mdu_iter: RTL and testbench

//  Parametrised iterative multiply/divide unit for the E stage of the pipelined MIPS core.

---
 rtl/mdu_pkg.sv | 24 ++
 rtl/mdu_div_step.sv | 22 ++
 rtl/mdu_iter.sv | 185 ++++++++++++++++++
 tb/tb_mdu_iter.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared op codes, FSM state encoding and accumulate mode for the iterative MDU.
package mdu_pkg;

    localparam logic [3:0] MDU_NOP   = 4'd0;
    localparam logic [3:0] MDU_MULT  = 4'd1;
    localparam logic [3:0] MDU_MULTU = 4'd2;
    localparam logic [3:0] MDU_DIV   = 4'd3;
    localparam logic [3:0] MDU_DIVU  = 4'd4;
    localparam logic [3:0] MDU_MFHI  = 4'd5;
    localparam logic [3:0] MDU_MFLO  = 4'd6;
    localparam logic [3:0] MDU_MTHI  = 4'd7;
    localparam logic [3:0] MDU_MTLO  = 4'd8;
    localparam logic [3:0] MDU_MADD  = 4'd9;
    localparam logic [3:0] MDU_MADDU = 4'd10;
    localparam logic [3:0] MDU_MSUB  = 4'd11;
    localparam logic [3:0] MDU_MSUBU = 4'd12;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;

    typedef enum logic [1:0] {ACC_NONE, ACC_ADD, ACC_SUB} acc_mode_t;

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-division step on unsigned magnitudes; q_in shifts the dividend out
// at the top while quotient bits shift in at the bottom.
module mdu_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic [WIDTH-1:0] q_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic [WIDTH-1:0] q_out
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    assign shifted = {rem_in, q_in[WIDTH-1]};
    assign diff    = shifted - {1'b0, divisor};
    // rem_in < divisor always holds, so a restored value never needs bit WIDTH
    assign rem_out = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
    assign q_out   = {q_in[WIDTH-2:0], ~diff[WIDTH]};

endmodule

// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit owning HI/LO: shift-add multiply, restoring divide.
// Define MDU_MADD_EN to accept MADD/MADDU/MSUB/MSUBU (accumulate into HI/LO at completion).
module mdu_iter
    import mdu_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int MUL_STEP = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             IntExcReq,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       MDUOp,
    output logic [WIDTH-1:0] MDUResult,
    output logic             Busy,
    output logic             Done
);

    localparam int            CW      = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] MUL_CYC = CW'(WIDTH / MUL_STEP);
    localparam logic [CW-1:0] DIV_CYC = CW'(WIDTH);
    localparam logic [CW-1:0] ONE     = CW'(1);

    logic [1:0]         state;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   hi, lo;
    logic [2*WIDTH-1:0] mcand, acc;
    logic [WIDTH-1:0]   mplier, rem, quo, divisor;
    logic               neg_q, neg_r, dz;
    acc_mode_t          acc_mode;

    logic      is_mul, is_div, mul_signed, div_signed;
    acc_mode_t op_acc;

    always_comb begin
        is_mul     = 1'b0;
        is_div     = 1'b0;
        mul_signed = 1'b0;
        div_signed = 1'b0;
        op_acc     = ACC_NONE;
        case (MDUOp)
            MDU_MULT:  begin is_mul = 1'b1; mul_signed = 1'b1; end
            MDU_MULTU: is_mul = 1'b1;
            MDU_DIV:   begin is_div = 1'b1; div_signed = 1'b1; end
            MDU_DIVU:  is_div = 1'b1;
`ifdef MDU_MADD_EN
            MDU_MADD:  begin is_mul = 1'b1; mul_signed = 1'b1; op_acc = ACC_ADD; end
            MDU_MADDU: begin is_mul = 1'b1; op_acc = ACC_ADD; end
            MDU_MSUB:  begin is_mul = 1'b1; mul_signed = 1'b1; op_acc = ACC_SUB; end
            MDU_MSUBU: begin is_mul = 1'b1; op_acc = ACC_SUB; end
`endif
            default: ;
        endcase
    end

    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;

    // MIN maps to itself, which is the correct magnitude when read unsigned
    assign a_neg = (mul_signed | div_signed) & A[WIDTH-1];
    assign b_neg = (mul_signed | div_signed) & B[WIDTH-1];
    assign a_mag = a_neg ? -A : A;
    assign b_mag = b_neg ? -B : B;

    logic [2*WIDTH-1:0] pp, prod_nx, prod, hilo_nx;

    always_comb begin
        pp = '0;
        for (int j = 0; j < MUL_STEP; j++)
            if (mplier[j]) pp = pp + (mcand << j);
    end

    assign prod_nx = acc + pp;
    assign prod    = neg_q ? -prod_nx : prod_nx;

    always_comb begin
        case (acc_mode)
            ACC_ADD: hilo_nx = {hi, lo} + prod;
            ACC_SUB: hilo_nx = {hi, lo} - prod;
            default: hilo_nx = prod;
        endcase
    end

    logic [WIDTH-1:0] rem_nx, quo_nx, q_fix, r_fix;

    mdu_div_step #(.WIDTH(WIDTH)) u_div_step (
        .rem_in (rem),
        .q_in   (quo),
        .divisor(divisor),
        .rem_out(rem_nx),
        .q_out  (quo_nx)
    );

    // divide by zero leaves rem = |A|, so the dividend-sign fix alone restores HI = A
    assign q_fix = dz ? '1 : (neg_q ? -quo_nx : quo_nx);
    assign r_fix = neg_r ? -rem_nx : rem_nx;

    logic last;
    assign last = (cnt == ONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            hi       <= '0;
            lo       <= '0;
            mcand    <= '0;
            acc      <= '0;
            mplier   <= '0;
            rem      <= '0;
            quo      <= '0;
            divisor  <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            dz       <= 1'b0;
            acc_mode <= ACC_NONE;
            Busy     <= 1'b0;
            Done     <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (state)
                ST_IDLE: if (!IntExcReq) begin
                    if (MDUOp == MDU_MTHI) hi <= A;
                    if (MDUOp == MDU_MTLO) lo <= A;
                    if (is_mul) begin
                        state    <= ST_MUL;
                        cnt      <= MUL_CYC;
                        Busy     <= 1'b1;
                        mcand    <= {{WIDTH{1'b0}}, a_mag};
                        mplier   <= b_mag;
                        acc      <= '0;
                        neg_q    <= a_neg ^ b_neg;
                        acc_mode <= op_acc;
                    end
                    if (is_div) begin
                        state   <= ST_DIV;
                        cnt     <= DIV_CYC;
                        Busy    <= 1'b1;
                        rem     <= '0;
                        quo     <= a_mag;
                        divisor <= b_mag;
                        neg_q   <= a_neg ^ b_neg;
                        neg_r   <= a_neg;
                        dz      <= (B == '0);
                    end
                end
                ST_MUL: begin
                    acc    <= prod_nx;
                    mcand  <= mcand << MUL_STEP;
                    mplier <= mplier >> MUL_STEP;
                    cnt    <= cnt - ONE;
                    if (last) begin
                        {hi, lo} <= hilo_nx;
                        state    <= ST_IDLE;
                        Busy     <= 1'b0;
                        Done     <= 1'b1;
                    end
                end
                ST_DIV: begin
                    rem <= rem_nx;
                    quo <= quo_nx;
                    cnt <= cnt - ONE;
                    if (last) begin
                        hi    <= r_fix;
                        lo    <= q_fix;
                        state <= ST_IDLE;
                        Busy  <= 1'b0;
                        Done  <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        case (MDUOp)
            MDU_MFHI: MDUResult = hi;
            MDU_MFLO: MDUResult = lo;
            default:  MDUResult = '0;
        endcase
    end

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter (WIDTH=32, MUL_STEP=4) against an arithmetic reference model.
module tb_mdu_iter;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        IntExcReq;
    logic [31:0] A, B;
    logic [3:0]  MDUOp;
    logic [31:0] MDUResult;
    logic        Busy, Done;

    int checks = 0;
    int errors = 0;
    logic [63:0] mhilo;

    mdu_iter #(.WIDTH(32), .MUL_STEP(4)) dut (
        .clk(clk), .reset(reset), .IntExcReq(IntExcReq), .A(A), .B(B),
        .MDUOp(MDUOp), .MDUResult(MDUResult), .Busy(Busy), .Done(Done)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] a, b,
                                          input logic [63:0] hilo);
        longint sa, sb;
        logic [63:0] sp, up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        sp = 64'(sa * sb);
        up = {32'd0, a} * {32'd0, b};
        case (op)
            MDU_MULT:  return sp;
            MDU_MULTU: return up;
            MDU_DIV: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                return {32'(sa % sb), 32'(sa / sb)};
            end
            MDU_DIVU: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            MDU_MTHI: return {a, hilo[31:0]};
            MDU_MTLO: return {hilo[63:32], a};
`ifdef MDU_MADD_EN
            MDU_MADD:  return hilo + sp;
            MDU_MADDU: return hilo + up;
            MDU_MSUB:  return hilo - sp;
            MDU_MSUBU: return hilo - up;
`endif
            default: return hilo;
        endcase
    endfunction

    function automatic int exp_lat(input logic [3:0] op);
        case (op)
            MDU_MULT, MDU_MULTU: return 8;
            MDU_DIV, MDU_DIVU:   return 32;
`ifdef MDU_MADD_EN
            MDU_MADD, MDU_MADDU, MDU_MSUB, MDU_MSUBU: return 8;
`endif
            default: return 0;
        endcase
    endfunction

    // Present one op for one edge, then count Busy cycles until it drops (bounded).
    task automatic issue(input logic [3:0] op, input logic [31:0] a, b, input logic irq,
                         output int lat, output logic done_end);
        @(negedge clk);
        MDUOp = op; A = a; B = b; IntExcReq = irq;
        @(posedge clk);
        #1;
        MDUOp = MDU_NOP; IntExcReq = 1'b0; A = $urandom; B = $urandom;
        lat = 0;
        done_end = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (Busy) lat++;
            else begin
                done_end = Done;
                break;
            end
        end
    endtask

    task automatic read_hilo(output logic [31:0] hi, lo);
        MDUOp = MDU_MFHI;
        #1 hi = MDUResult;
        MDUOp = MDU_MFLO;
        #1 lo = MDUResult;
        MDUOp = MDU_NOP;
    endtask

    task automatic test_reset;
        logic [31:0] hi, lo;
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", Busy); end
        checks++; if (Done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", Done); end
        read_hilo(hi, lo);
        checks++; if (hi !== 32'd0) begin errors++; $display("FAIL reset_hi got %h exp 0", hi); end
        checks++; if (lo !== 32'd0) begin errors++; $display("FAIL reset_lo got %h exp 0", lo); end
    endtask

    task automatic test_mult;
        logic [3:0]  ops [2] = '{MDU_MULT, MDU_MULTU};
        logic [31:0] ehi [2] = '{32'hFFFF_FFFF, 32'h0000_0001};
        int lat;
        logic dn;
        logic [31:0] hi, lo;
        for (int i = 0; i < 2; i++) begin
            issue(ops[i], 32'hFFFF_FFFF, 32'd2, 1'b0, lat, dn);
            read_hilo(hi, lo);
            checks++; if (lat !== 8) begin errors++; $display("FAIL mult_lat[%0d] got %0d exp 8", i, lat); end
            checks++; if (dn !== 1'b1) begin errors++; $display("FAIL mult_done[%0d] got %b exp 1", i, dn); end
            checks++; if (hi !== ehi[i]) begin errors++; $display("FAIL mult_hi[%0d] got %h exp %h", i, hi, ehi[i]); end
            checks++; if (lo !== 32'hFFFF_FFFE) begin errors++; $display("FAIL mult_lo[%0d] got %h exp fffffffe", i, lo); end
            @(negedge clk);
            checks++; if (Done !== 1'b0) begin errors++; $display("FAIL done_pulse[%0d] got %b exp 0", i, Done); end
        end
    endtask

    task automatic test_div;
        logic [3:0]  ops [5] = '{MDU_DIV, MDU_DIVU, MDU_DIV, MDU_DIV, MDU_DIVU};
        logic [31:0] da  [5] = '{32'hFFFF_FFF9, 32'd7, 32'h8000_0000, 32'hFFFF_FFFB, 32'd100};
        logic [31:0] db  [5] = '{32'd2, 32'd0, 32'hFFFF_FFFF, 32'd0, 32'd7};
        logic [31:0] ehi [5] = '{32'hFFFF_FFFF, 32'd7, 32'd0, 32'hFFFF_FFFB, 32'd2};
        logic [31:0] elo [5] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'd14};
        int lat;
        logic dn;
        logic [31:0] hi, lo;
        for (int i = 0; i < 5; i++) begin
            issue(ops[i], da[i], db[i], 1'b0, lat, dn);
            read_hilo(hi, lo);
            checks++; if (lat !== 32) begin errors++; $display("FAIL div_lat[%0d] got %0d exp 32", i, lat); end
            checks++; if (dn !== 1'b1) begin errors++; $display("FAIL div_done[%0d] got %b exp 1", i, dn); end
            checks++; if (hi !== ehi[i]) begin errors++; $display("FAIL div_hi[%0d] got %h exp %h", i, hi, ehi[i]); end
            checks++; if (lo !== elo[i]) begin errors++; $display("FAIL div_lo[%0d] got %h exp %h", i, lo, elo[i]); end
        end
    endtask

    task automatic test_intexc;
        int lat;
        logic dn;
        logic [31:0] hi, lo;
        issue(MDU_MTHI, 32'hAAAA_0001, 32'd0, 1'b0, lat, dn);
        issue(MDU_MTLO, 32'hBBBB_0002, 32'd0, 1'b0, lat, dn);
        issue(MDU_MULT, 32'd5, 32'd5, 1'b1, lat, dn);
        checks++; if (lat !== 0) begin errors++; $display("FAIL irq_busy got %0d cycles exp 0", lat); end
        issue(MDU_MTLO, 32'd9, 32'd0, 1'b1, lat, dn);
        read_hilo(hi, lo);
        checks++; if (hi !== 32'hAAAA_0001) begin errors++; $display("FAIL irq_hi got %h exp aaaa0001", hi); end
        checks++; if (lo !== 32'hBBBB_0002) begin errors++; $display("FAIL irq_lo got %h exp bbbb0002", lo); end
    endtask

    task automatic test_busy_ignore;
        int lat;
        logic dn;
        logic [31:0] hi, lo;
        issue(MDU_MTLO, 32'd99, 32'd0, 1'b0, lat, dn);
        @(negedge clk);
        MDUOp = MDU_MULT; A = 32'd7; B = 32'd6;
        @(posedge clk);
        #1;
        lat = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (i == 0) begin MDUOp = MDU_MTLO; A = 32'd5; end
            if (i == 3) begin MDUOp = MDU_DIVU; A = 32'd50; B = 32'd3; end
            if (i == 5) begin
                MDUOp = MDU_MFLO;
                #1;
                checks++; if (MDUResult !== 32'd99) begin errors++; $display("FAIL busy_mflo_old got %h exp 63", MDUResult); end
                MDUOp = MDU_NOP;
            end
            if (Busy) lat++;
            else break;
        end
        read_hilo(hi, lo);
        checks++; if (lat !== 8) begin errors++; $display("FAIL busy_ign_lat got %0d exp 8", lat); end
        checks++; if (hi !== 32'd0) begin errors++; $display("FAIL busy_ign_hi got %h exp 0", hi); end
        checks++; if (lo !== 32'd42) begin errors++; $display("FAIL busy_ign_lo got %h exp 2a", lo); end
    endtask

    task automatic test_reset_midop;
        int lat;
        logic dn;
        logic [31:0] hi, lo;
        issue(MDU_MTHI, 32'h1234, 32'd0, 1'b0, lat, dn);
        @(negedge clk);
        MDUOp = MDU_DIV; A = 32'd1000; B = 32'd3;
        @(posedge clk);
        #1 MDUOp = MDU_NOP;
        repeat (10) @(negedge clk);
        checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL midop_busy got %b exp 1", Busy); end
        #1 reset = 1'b1;
        #1;
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL rst_async_busy got %b exp 0", Busy); end
        checks++; if (Done !== 1'b0) begin errors++; $display("FAIL rst_async_done got %b exp 0", Done); end
        read_hilo(hi, lo);
        checks++; if (hi !== 32'd0) begin errors++; $display("FAIL rst_async_hi got %h exp 0", hi); end
        checks++; if (lo !== 32'd0) begin errors++; $display("FAIL rst_async_lo got %h exp 0", lo); end
        @(negedge clk);
        reset = 1'b0;
        issue(MDU_MULT, 32'd3, 32'd4, 1'b0, lat, dn);
        read_hilo(hi, lo);
        checks++; if (lat !== 8) begin errors++; $display("FAIL post_rst_lat got %0d exp 8", lat); end
        checks++; if (lo !== 32'd12) begin errors++; $display("FAIL post_rst_lo got %h exp c", lo); end
    endtask

    task automatic test_madd;
        int lat;
        logic dn;
        logic [31:0] hi, lo;
        issue(MDU_MTHI, 32'd0, 32'd0, 1'b0, lat, dn);
        issue(MDU_MTLO, 32'd10, 32'd0, 1'b0, lat, dn);
        issue(MDU_MADD, 32'd3, 32'd4, 1'b0, lat, dn);
        read_hilo(hi, lo);
`ifdef MDU_MADD_EN
        checks++; if (lat !== 8) begin errors++; $display("FAIL madd_lat got %0d exp 8", lat); end
        checks++; if (lo !== 32'd22) begin errors++; $display("FAIL madd_lo got %h exp 16", lo); end
        issue(MDU_MSUB, 32'd5, 32'd5, 1'b0, lat, dn);
        read_hilo(hi, lo);
        checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL msub_hi got %h exp ffffffff", hi); end
        checks++; if (lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL msub_lo got %h exp fffffffd", lo); end
`else
        checks++; if (lat !== 0) begin errors++; $display("FAIL madd_off_busy got %0d exp 0", lat); end
        checks++; if (dn !== 1'b0) begin errors++; $display("FAIL madd_off_done got %b exp 0", dn); end
        checks++; if (lo !== 32'd10) begin errors++; $display("FAIL madd_off_lo got %h exp a", lo); end
`endif
    endtask

    function automatic logic [31:0] rnd_opnd();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 20));
            default: return 32'($urandom);
        endcase
    endfunction

    task automatic test_random;
        logic [3:0] ops [10] = '{MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU, MDU_MTHI, MDU_MTLO,
                                 MDU_MADD, MDU_MADDU, MDU_MSUB, MDU_MSUBU};
        logic [3:0]  op;
        logic [31:0] a, b, hi, lo;
        logic [63:0] exp;
        logic        irq, dn;
        int          lat, elat;
        issue(MDU_MTHI, 32'h0F0F_0F0F, 32'd0, 1'b0, lat, dn);
        issue(MDU_MTLO, 32'h1357_9BDF, 32'd0, 1'b0, lat, dn);
        mhilo = 64'h0F0F_0F0F_1357_9BDF;
        for (int n = 0; n < 60; n++) begin
            op  = ops[$urandom_range(0, 9)];
            a   = rnd_opnd();
            b   = rnd_opnd();
            irq = ($urandom_range(0, 7) == 0);
            exp  = irq ? mhilo : model(op, a, b, mhilo);
            elat = irq ? 0 : exp_lat(op);
            issue(op, a, b, irq, lat, dn);
            read_hilo(hi, lo);
            checks++; if (lat !== elat) begin errors++; $display("FAIL rnd_lat[%0d] op %0d got %0d exp %0d", n, op, lat, elat); end
            checks++; if (dn !== (elat != 0)) begin errors++; $display("FAIL rnd_done[%0d] op %0d got %b exp %b", n, op, dn, elat != 0); end
            checks++; if (hi !== exp[63:32]) begin errors++; $display("FAIL rnd_hi[%0d] op %0d a %h b %h got %h exp %h", n, op, a, b, hi, exp[63:32]); end
            checks++; if (lo !== exp[31:0]) begin errors++; $display("FAIL rnd_lo[%0d] op %0d a %h b %h got %h exp %h", n, op, a, b, lo, exp[31:0]); end
            mhilo = exp;
        end
    endtask

    initial begin
        reset = 1'b1; IntExcReq = 1'b0; MDUOp = MDU_NOP; A = '0; B = '0;
        repeat (2) @(negedge clk);
        test_reset;
        @(negedge clk);
        reset = 1'b0;
        test_mult;
        test_div;
        test_intexc;
        test_busy_ignore;
        test_reset_midop;
        test_madd;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
